// File: rtl/mirror_display_pkg.sv
// Shared types and constants for the mirror display channel sequencer.
package mirror_display_pkg;

  typedef enum logic [1:0] {
    StManual,
    StScroll,
    StFrozen
  } seq_state_e;

  localparam int unsigned CH_TEMP        = 0;
  localparam int unsigned CH_AVG_MPG     = 1;
  localparam int unsigned CH_INST_MPG    = 2;
  localparam int unsigned CH_MILES       = 3;
  localparam int unsigned DATA_W_DEFAULT = 8;

  // Next channel index with wrap from num_ch-1 back to 0.
  function automatic int unsigned next_ch(input int unsigned ch, input int unsigned num_ch);
    return (ch + 1 >= num_ch) ? 0 : ch + 1;
  endfunction

endpackage

// File: rtl/mirror_dwell_timer.sv
// Dwell counter for auto-scroll: counts 0..DWELL_CYCLES-1 and flags the terminal count.
module mirror_dwell_timer #(
  parameter int unsigned DWELL_CYCLES = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic freeze_i,
  input  logic run_i,
  input  logic restart_i,
  output logic tc_o
);

  localparam int unsigned CntW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DWELL_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc_o = run_i && !freeze_i && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (freeze_i) begin
      cnt_d = cnt_q;
    end else if (restart_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mirror_display_sequencer.sv
// Mirror display channel sequencer: manual select, timed auto-scroll, freeze, change strobe.
// Optional low-reading alarm override enabled by defining MIRROR_ALARM_EN.
module mirror_display_sequencer
  import mirror_display_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DATA_W       = DATA_W_DEFAULT,
  parameter int unsigned DWELL_CYCLES = 50_000_000,
`ifdef MIRROR_ALARM_EN
  parameter int unsigned ALARM_CH     = CH_MILES,
`endif
  localparam int unsigned SEL_W       = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] sensor_data,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     next_btn,
  input  logic                     hold,
`ifdef MIRROR_ALARM_EN
  input  logic [DATA_W-1:0]        alarm_thresh,
  output logic                     alarm,
`endif
  output logic [DATA_W-1:0]        display,
  output logic [SEL_W-1:0]         display_ch,
  output logic                     display_upd
);

  logic [DATA_W-1:0] ch_data [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_data[k] = sensor_data[k*DATA_W +: DATA_W];
  end

  seq_state_e        state_q, state_d;
  logic [SEL_W-1:0]  cur_ch_q, cur_ch_d;
  logic [DATA_W-1:0] display_q, display_d;
  logic [SEL_W-1:0]  display_ch_q, display_ch_d;
  logic              display_upd_q, display_upd_d;
  logic [SEL_W-1:0]  sel_clamped;
  logic              timer_run, timer_restart, dwell_tc;

`ifdef MIRROR_ALARM_EN
  logic alarm_q, alarm_d;
  assign alarm_d = (ch_data[ALARM_CH] < alarm_thresh);
  assign alarm   = alarm_q;
`endif

  assign sel_clamped = (int'(sel) >= NUM_CH) ? SEL_W'(NUM_CH - 1) : sel;

  mirror_dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell_timer (
    .clk_i    (clk),
    .rst_i    (rst),
    .freeze_i (hold),
    .run_i    (timer_run),
    .restart_i(timer_restart),
    .tc_o     (dwell_tc)
  );

  always_comb begin
    state_d       = state_q;
    cur_ch_d      = cur_ch_q;
    display_d     = display_q;
    display_ch_d  = display_ch_q;
    timer_run     = 1'b0;
    timer_restart = 1'b0;
    if (hold) begin
      state_d = StFrozen;
    end else begin
      state_d = mode ? StScroll : StManual;
`ifdef MIRROR_ALARM_EN
      if (alarm_q) begin
        cur_ch_d      = SEL_W'(ALARM_CH);
        timer_restart = 1'b1;
      end else
`endif
      if (mode) begin
        // A fresh dwell always starts when leaving manual; resuming from freeze keeps the count.
        timer_run     = 1'b1;
        timer_restart = next_btn || (state_q == StManual);
        if (next_btn || dwell_tc) begin
          cur_ch_d = SEL_W'(next_ch(int'(cur_ch_q), NUM_CH));
        end
      end else begin
        cur_ch_d      = sel_clamped;
        timer_restart = 1'b1;
      end
      display_d    = ch_data[cur_ch_q];
      display_ch_d = cur_ch_q;
    end
    display_upd_d = !hold && ({display_d, display_ch_d} != {display_q, display_ch_q});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StManual;
      cur_ch_q      <= '0;
      display_q     <= '0;
      display_ch_q  <= '0;
      display_upd_q <= 1'b0;
`ifdef MIRROR_ALARM_EN
      alarm_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cur_ch_q      <= cur_ch_d;
      display_q     <= display_d;
      display_ch_q  <= display_ch_d;
      display_upd_q <= display_upd_d;
`ifdef MIRROR_ALARM_EN
      alarm_q       <= alarm_d;
`endif
    end
  end

  assign display     = display_q;
  assign display_ch  = display_ch_q;
  assign display_upd = display_upd_q;

endmodule

// File: tb/tb_mirror_display_sequencer.sv
// Directed bench for mirror_display_sequencer (4-channel main instance, 3-channel clamp instance).
module tb_mirror_display_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sensors;
  logic [23:0] sensors3;
  logic        mode, next_btn, hold;
  logic [1:0]  sel, sel3;
  logic [7:0]  display, display3;
  logic [1:0]  display_ch, display_ch3;
  logic        display_upd, display_upd3;
`ifdef MIRROR_ALARM_EN
  logic [7:0]  alarm_thresh;
  logic        alarm, alarm3;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mirror_display_sequencer #(
    .NUM_CH      (4),
    .DATA_W      (8),
    .DWELL_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sensor_data (sensors),
    .mode        (mode),
    .sel         (sel),
    .next_btn    (next_btn),
    .hold        (hold),
`ifdef MIRROR_ALARM_EN
    .alarm_thresh(alarm_thresh),
    .alarm       (alarm),
`endif
    .display     (display),
    .display_ch  (display_ch),
    .display_upd (display_upd)
  );

  mirror_display_sequencer #(
    .NUM_CH      (3),
    .DATA_W      (8),
`ifdef MIRROR_ALARM_EN
    .ALARM_CH    (2),
`endif
    .DWELL_CYCLES(4)
  ) dut3 (
    .clk         (clk),
    .rst         (rst),
    .sensor_data (sensors3),
    .mode        (1'b0),
    .sel         (sel3),
    .next_btn    (1'b0),
    .hold        (1'b0),
`ifdef MIRROR_ALARM_EN
    .alarm_thresh(8'h00),
    .alarm       (alarm3),
`endif
    .display     (display3),
    .display_ch  (display_ch3),
    .display_upd (display_upd3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic [1:0] ch,
                           input logic upd);
    check({tag, ".display"}, 32'(display), 32'(d));
    check({tag, ".ch"}, 32'(display_ch), 32'(ch));
    check({tag, ".upd"}, 32'(display_upd), 32'(upd));
  endtask

  initial begin
    rst      = 1'b1;
    sensors  = 32'h44332211;
    sensors3 = 24'h332211;
    mode     = 1'b0;
    sel      = 2'd0;
    sel3     = 2'd3;
    next_btn = 1'b0;
    hold     = 1'b0;
`ifdef MIRROR_ALARM_EN
    alarm_thresh = 8'h00;
`endif
    step(2);
    check_out("reset", 8'h00, 2'd0, 1'b0);
    check("reset3.display", 32'(display3), 32'h0);

    // First cycle out of reset shows channel 0; then sel=2 takes two cycles.
    rst = 1'b0;
    step(1);
    check_out("first", 8'h11, 2'd0, 1'b1);
    step(1);
    check_out("steady", 8'h11, 2'd0, 1'b0);
    check("clamp.display", 32'(display3), 32'h33);
    check("clamp.ch", 32'(display_ch3), 32'd2);
    sel = 2'd2;
    step(1);
    check_out("sel_lat1", 8'h11, 2'd0, 1'b0);
    step(1);
    check_out("sel_lat2", 8'h33, 2'd2, 1'b1);
    step(1);
    check_out("sel_after", 8'h33, 2'd2, 1'b0);

    sel = 2'd0;
    step(2);
    check_out("sel0", 8'h11, 2'd0, 1'b1);

    // Auto-scroll: channel 0 until the 5th edge, then 4 cycles each.
    mode = 1'b1;
    for (int n = 0; n <= 20; n++) begin
      int exp_ch;
      step(1);
      exp_ch = (n < 5) ? 0 : (((n - 5) / 4 + 1) % 4);
      check($sformatf("scroll%0d.ch", n), 32'(display_ch), 32'(exp_ch));
      check($sformatf("scroll%0d.upd", n), 32'(display_upd),
            32'((n == 5) || (n == 9) || (n == 13) || (n == 17)));
    end
    step(1);
    check("btn_pre.ch", 32'(display_ch), 32'd1);
    next_btn = 1'b1;
    step(1);
    next_btn = 1'b0;
    check("btn_edge.ch", 32'(display_ch), 32'd1);
    for (int n = 0; n < 4; n++) begin
      step(1);
      check($sformatf("btn_dwell%0d.ch", n), 32'(display_ch), 32'd2);
    end
    step(1);
    check("btn_next.ch", 32'(display_ch), 32'd3);

    // Freeze one cycle into channel 1's dwell and change its sensor underneath.
    step(8);
    check_out("pre_hold", 8'h22, 2'd1, 1'b1);
    hold    = 1'b1;
    sensors = 32'h44339911;
    for (int n = 0; n < 3; n++) begin
      step(1);
      check_out($sformatf("hold%0d", n), 8'h22, 2'd1, 1'b0);
    end
    hold = 1'b0;
    step(1);
    check_out("release", 8'h99, 2'd1, 1'b1);
    step(1);
    check_out("resume1", 8'h99, 2'd1, 1'b0);
    step(1);
    check_out("resume2", 8'h99, 2'd1, 1'b0);
    step(1);
    check_out("resume_adv", 8'h33, 2'd2, 1'b1);

    // next_btn coinciding with terminal count advances only once.
    step(2);
    check("tc_pre.ch", 32'(display_ch), 32'd2);
    next_btn = 1'b1;
    step(1);
    next_btn = 1'b0;
    check("tc_edge.ch", 32'(display_ch), 32'd2);
    step(1);
    check("tc_single.ch", 32'(display_ch), 32'd3);
    step(1);
    check("tc_stay.ch", 32'(display_ch), 32'd3);

    // Reset wins over hold and next_btn.
    rst      = 1'b1;
    hold     = 1'b1;
    next_btn = 1'b1;
    step(1);
    check_out("rst_mid", 8'h00, 2'd0, 1'b0);
    rst      = 1'b0;
    hold     = 1'b0;
    next_btn = 1'b0;
    mode     = 1'b0;
    sel      = 2'd3;
    step(1);
    check_out("post_rst1", 8'h11, 2'd0, 1'b1);
    step(1);
    check_out("post_rst2", 8'h44, 2'd3, 1'b1);

`ifdef MIRROR_ALARM_EN
    check("alarm_idle", 32'(alarm), 32'd0);
    alarm_thresh = 8'h10;
    sensors      = 32'h0F332211;
    mode         = 1'b1;
    step(3);
    check("alarm_on", 32'(alarm), 32'd1);
    check_out("alarm_show", 8'h0F, 2'd3, 1'b0);
    step(6);
    check_out("alarm_held", 8'h0F, 2'd3, 1'b0);
    sensors = 32'h44332211;
    step(1);
    check("alarm_off", 32'(alarm), 32'd0);
    check_out("alarm_clr", 8'h44, 2'd3, 1'b1);
    step(4);
    check("alarm_dwell.ch", 32'(display_ch), 32'd3);
    step(1);
    check("alarm_wrap.ch", 32'(display_ch), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mirror_display_sequencer.md
# mirror_display_sequencer

Parametrised channel sequencer for the automobile mirror display: selects one of NUM_CH sensor channels (temperature, average mpg, instantaneous mpg, miles remaining, …) and presents it as a registered display word. It replaces the fixed four-way combinational selector with manual selection, timed auto-scroll, freeze, and a change strobe. It sits between the sensor registers and the mirror display driver.

## Interface
- NUM_CH, 4, number of sensor channels (2..16)
- DATA_W, 8, width of each channel and of the display word
- DWELL_CYCLES, 50_000_000, clock cycles each channel is shown in auto-scroll (>=2)
- SEL_W, $clog2(NUM_CH), derived, channel index width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- sensor_data  in  NUM_CH*DATA_W  packed channels, channel k at [k*DATA_W +: DATA_W]
- mode  in  1  0 = manual, 1 = auto-scroll
- sel  in  SEL_W  manual channel select
- next_btn  in  1  single-cycle pulse: advance one channel in auto-scroll
- hold  in  1  freeze display word and channel while high
- display  out  DATA_W  registered display word
- display_ch  out  SEL_W  channel currently shown
- display_upd  out  1  one-cycle pulse when display or display_ch changes

## Operation
- States: MANUAL, SCROLL, FROZEN. Reset state MANUAL.
- Priority each cycle: rst > hold > mode.
- MANUAL: cur_ch <= sel; sel >= NUM_CH clamps to NUM_CH-1. next_btn ignored. Dwell counter held at 0.
- SCROLL: dwell counter counts 0..DWELL_CYCLES-1; at terminal count cur_ch advances and counter restarts at 0. next_btn advances cur_ch immediately and restarts counter; next_btn on the terminal-count cycle advances once, not twice.
- Wrap: cur_ch NUM_CH-1 advances to 0.
- MANUAL→SCROLL: scrolling starts from the current cur_ch, counter at 0.
- SCROLL→MANUAL: cur_ch <= sel next cycle.
- FROZEN (hold=1): display, display_ch, cur_ch, dwell counter all held; sensor changes not shown; next_btn dropped. On hold release go to MANUAL or SCROLL per mode; SCROLL resumes with the held counter value.
- display <= sensor_data slice of cur_ch every non-frozen cycle, so live value changes on the shown channel propagate.
- display_upd = 1 for one cycle when the newly registered {display, display_ch} differs from the previous value; never asserted in FROZEN or on the cycle reset is applied.

## Timing
- Reset values: display = 0, display_ch = 0, display_upd = 0, counter = 0, state MANUAL.
- Latency: sel or sensor_data change → display/display_ch updated 2 cycles later (cur_ch register, then output register); display_upd in the same cycle as the output change.
- next_btn in SCROLL: display_ch changes 2 cycles after the pulse.
- Auto-scroll period exactly DWELL_CYCLES cycles per channel.
- rst mid-scroll: all state cleared next edge; no display_upd pulse.

## Configuration
- MIRROR_ALARM_EN: when defined, adds parameters ALARM_CH (default 3, miles remaining) and port alarm_thresh in DATA_W plus output alarm out 1. alarm registered = (ALARM_CH data < alarm_thresh), unsigned. While alarm=1 and not FROZEN, cur_ch is forced to ALARM_CH in both modes, counter held at 0; on alarm clear normal mode behaviour resumes from ALARM_CH. hold still overrides alarm. Reset value alarm = 0.
- Without the macro: no alarm ports/parameters, behaviour as above.

## Structure
- Package mirror_display_pkg: state enum (MANUAL, SCROLL, FROZEN), default channel index constants (CH_TEMP=0, CH_AVG_MPG=1, CH_INST_MPG=2, CH_MILES=3), DATA_W default.
- One sub-module: mirror_dwell_timer (counter, terminal-count pulse, restart and hold inputs).

## Test plan
- Reset: rst=1 two cycles with nonzero sensors → display=0, display_ch=0, display_upd=0.
- Manual: sensors {0x11,0x22,0x33,0x44}, sel=2 → display=0x33, display_ch=2 after 2 cycles, one display_upd pulse; sel=3 with NUM_CH=3 clamps to channel 2.
- Auto-scroll DWELL_CYCLES=4: channel sequence 0,1,2,3,0 each held exactly 4 cycles; next_btn at count 1 advances immediately and restarts 4-cycle dwell.
- Hold: assert hold mid-scroll, change displayed sensor 0x22→0x99 → display stays 0x22, no upd; release → scrolling resumes with remaining dwell, value 0x99 appears with upd.
- Simultaneous: next_btn on terminal-count cycle → single advance; rst with hold and next_btn → reset values.
- MIRROR_ALARM_EN: ALARM_CH=3, alarm_thresh=0x10, channel 3 drops 0x44→0x0F in SCROLL → alarm=1, display_ch=3, display=0x0F held; restore 0x44 → alarm=0, scroll resumes 3→0.
